vx_ibuffer: RTL

Per-warp instruction buffer between the decode stage and the scoreboard staging buffers. Accepts one decoded instruction per cycle, tagged with its warp id, and queues it in that warp's FIFO. Presents each warp's oldest instruction on a dedicated valid/ready stream to the scoreboard. Supports per-warp flush and exports per-warp occupancy to the warp scheduler for fetch throttling.

---
 rtl/VX_gpu_pkg.sv | 41 ++++
 rtl/vx_ibuf_fifo.sv | 67 ++++++
 rtl/vx_ibuffer.sv | 60 ++++++
 3 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared GPU pipeline definitions: instruction-buffer sizing, warp id type and
// the decoded-instruction layout handed from decode to the scoreboard.
package VX_gpu_pkg;

    localparam int IBUF_NUM_WARPS = 4;
    localparam int IBUF_DEPTH     = 2;
    localparam int IBUF_CNT_W     = $clog2(IBUF_DEPTH + 1);
    localparam int NW_BITS        = $clog2(IBUF_NUM_WARPS);

    typedef logic [NW_BITS-1:0] wid_t;

    typedef enum logic [2:0] {
        EX_ALU = 3'd0,
        EX_LSU = 3'd1,
        EX_FPU = 3'd2,
        EX_SFU = 3'd3,
        EX_TCU = 3'd4
    } ex_type_e;

    // Payload as the scoreboard unpacks it; the buffer itself treats it as opaque bits.
    typedef struct packed {
        logic [15:0] uuid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        ex_type_e    ex_type;
        logic [3:0]  op_type;
        logic [7:0]  op_args;
        logic        wb;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
    } ibuf_data_t;

    localparam int IBUF_DATAW = $bits(ibuf_data_t);

    function automatic int ibuf_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vx_ibuf_fifo.sv
// Single-warp instruction queue: pointer/count bookkeeping plus the payload
// flop array. Flush returns the queue to its empty, zero-pointer state.
module vx_ibuf_fifo
    import VX_gpu_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    parameter int DATAW = 64,
    parameter int CNT_W = ibuf_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    // Re-qualified locally so the queue can never over/underflow whatever the caller does.
    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Payload is deliberately left unreset; validity comes only from the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    assign data_out = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule

// File: rtl/vx_ibuffer.sv
// Per-warp instruction buffer: one shared decode push port steered by warp id,
// one valid/ready head stream per warp towards the scoreboard.
module vx_ibuffer
    import VX_gpu_pkg::*;
#(
    parameter int NUM_WARPS = IBUF_NUM_WARPS,
    parameter int DEPTH     = IBUF_DEPTH,
    parameter int DATAW     = 64,
    parameter int WID_W     = $clog2(NUM_WARPS),
    parameter int CNT_W     = ibuf_cnt_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       decode_valid,
    input  logic [WID_W-1:0]           decode_wid,
    input  logic [DATAW-1:0]           decode_data,
    output logic                       decode_ready,
    input  logic [NUM_WARPS-1:0]       flush,
    output logic [NUM_WARPS-1:0]       ibuf_valid,
    output logic [NUM_WARPS*DATAW-1:0] ibuf_data,
    input  logic [NUM_WARPS-1:0]       ibuf_ready,
    output logic [NUM_WARPS*CNT_W-1:0] ibuf_count
);

    logic [NUM_WARPS-1:0] w_wid_hit;
    logic [NUM_WARPS-1:0] w_push;
    logic [NUM_WARPS-1:0] w_pop;
    logic [NUM_WARPS-1:0] w_full;
    logic [NUM_WARPS-1:0] w_empty;

    // A full warp refuses even when it pops this cycle: no pass-through path.
    assign decode_ready = |(w_wid_hit & ~w_full & ~flush);

    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            assign w_wid_hit[gi]  = (decode_wid == WID_W'(gi));
            assign w_push[gi]     = decode_valid & decode_ready & w_wid_hit[gi];
            assign w_pop[gi]      = ibuf_valid[gi] & ibuf_ready[gi] & ~flush[gi];
            assign ibuf_valid[gi] = ~w_empty[gi];

            vx_ibuf_fifo #(
                .DEPTH (DEPTH),
                .DATAW (DATAW),
                .CNT_W (CNT_W)
            ) u_fifo (
                .clk      (clk),
                .reset_n  (reset_n),
                .push     (w_push[gi]),
                .pop      (w_pop[gi]),
                .flush    (flush[gi]),
                .data_in  (decode_data),
                .data_out (ibuf_data[gi*DATAW +: DATAW]),
                .count    (ibuf_count[gi*CNT_W +: CNT_W]),
                .full     (w_full[gi]),
                .empty    (w_empty[gi])
            );
        end
    endgenerate

endmodule
